// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: debug run controller sitting between the PDU control bus and
// the pipelined CPU. Sequences CPU reset, halt, free run and single step, and
// gates the CPU clock enable from commands, a PC breakpoint and cpu_stop.
// Build option: define RUN_WATCHDOG_EN to add a run-length watchdog that halts
// a free run after WDOG_CYCLES enabled cycles (halt_cause = 3).
//
// state  | meaning
// S_RST  | CPU held in reset for RST_CYCLES cycles
// S_HALT | CPU stopped, waiting for a step/run command
// S_RUN  | free run, gated by breakpoint / cpu_stop / halt
// S_STEP | exactly one enabled CPU cycle, then back to halt
module cpu_run_ctrl #(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned WDOG_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cmd_run,
  input  logic            cmd_step,
  input  logic            cmd_halt,
  input  logic            cmd_rst,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] if_pc,
  input  logic            cpu_stop,
  output logic            cpu_run,
  output logic            cpu_rstn,
  output logic            halted,
  output logic [1:0]      halt_cause,
  output logic [31:0]     cycle_cnt
);

  typedef enum logic [1:0] {S_RST, S_HALT, S_RUN, S_STEP} state_t;

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  // Elaboration-time sanity check on the parameter ranges.
  if (RST_CYCLES < 1 || RST_CYCLES > 255 || WDOG_CYCLES == 0) begin : g_bad_param
    $error("cpu_run_ctrl: RST_CYCLES must be 1..255 and WDOG_CYCLES nonzero");
  end

  state_t      state, state_nxt;
  logic [7:0]  rst_cnt, rst_cnt_nxt;
  logic        bp_skip, bp_skip_nxt;
  logic [1:0]  halt_cause_nxt;
  logic        bp_hit;
  logic        wdog_hit;
  logic        rst_req;

  // A reset command only matters once the CPU is out of reset.
  assign rst_req = cmd_rst && (state != S_RST);

`ifdef RUN_WATCHDOG_EN
  localparam logic [31:0] WDOG_LIMIT = 32'(WDOG_CYCLES);
  logic [31:0] wdog_cnt;

  // Watchdog counts enabled run cycles; held at zero outside S_RUN so it
  // starts fresh on every entry into a free run.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 wdog_cnt <= '0;
    else if (state != S_RUN)   wdog_cnt <= '0;
    else if (cpu_run)          wdog_cnt <= wdog_cnt + 32'd1;
  end

  assign wdog_hit = (state == S_RUN) && (wdog_cnt >= WDOG_LIMIT);
`else
  assign wdog_hit = 1'b0;
`endif

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_RST;
      rst_cnt    <= '0;
      bp_skip    <= 1'b0;
      halt_cause <= 2'd0;
    end else begin
      state      <= state_nxt;
      rst_cnt    <= rst_cnt_nxt;
      bp_skip    <= bp_skip_nxt;
      halt_cause <= halt_cause_nxt;
    end
  end

  // Executed-cycle counter: saturating, cleared only by a reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              cycle_cnt <= '0;
    else if (rst_req)                       cycle_cnt <= '0;
    else if (cpu_run && (cycle_cnt != '1))  cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Next-state, clock-enable gating and halt-cause selection.
  always_comb begin
    state_nxt      = state;
    rst_cnt_nxt    = rst_cnt;
    bp_skip_nxt    = bp_skip;
    halt_cause_nxt = halt_cause;
    cpu_run        = 1'b0;
    bp_hit         = bp_en && !bp_skip && (if_pc == bp_addr);

    case (state)
      S_RST: begin
        rst_cnt_nxt = rst_cnt + 8'd1;
        if (rst_cnt == RST_LAST) begin
          state_nxt      = S_HALT;
          rst_cnt_nxt    = '0;
          halt_cause_nxt = 2'd0;
        end
      end
      S_HALT: begin
        // cmd_halt outranks step/run, and is itself a no-op here.
        if (!cmd_halt) begin
          if (cmd_step) begin
            state_nxt      = S_STEP;
            bp_skip_nxt    = 1'b1;
            halt_cause_nxt = 2'd0;
          end else if (cmd_run) begin
            state_nxt      = S_RUN;
            bp_skip_nxt    = 1'b1;
            halt_cause_nxt = 2'd0;
          end
        end
      end
      S_STEP: begin
        cpu_run        = 1'b1;
        state_nxt      = S_HALT;
        halt_cause_nxt = 2'd0;
      end
      S_RUN: begin
        cpu_run = !bp_hit && !cpu_stop && !cmd_halt && !cmd_rst && !wdog_hit;
        if (cpu_run) bp_skip_nxt = 1'b0;
        if (cmd_halt) begin
          state_nxt      = S_HALT;
          halt_cause_nxt = 2'd0;
        end else if (cpu_stop) begin
          state_nxt      = S_HALT;
          halt_cause_nxt = 2'd2;
        end else if (bp_hit) begin
          state_nxt      = S_HALT;
          halt_cause_nxt = 2'd1;
        end else if (wdog_hit) begin
          state_nxt      = S_HALT;
          halt_cause_nxt = 2'd3;
        end
      end
      default: state_nxt = S_RST;
    endcase

    if (rst_req) begin
      state_nxt      = S_RST;
      rst_cnt_nxt    = '0;
      halt_cause_nxt = 2'd0;
    end
  end

  assign cpu_rstn = (state != S_RST);
  assign halted   = (state == S_HALT);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: directed scenarios plus a randomized run, all
// checked against a cycle-level behavioural model of the run controller.
module tb_cpu_run_ctrl;

  localparam int RST_CYC = 4;
  localparam int WDOG    = 20;

  localparam int M_RST  = 0;
  localparam int M_HALT = 1;
  localparam int M_RUN  = 2;
  localparam int M_STEP = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0, cmd_rst = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] if_pc = '0;
  logic        cpu_stop = 1'b0;
  logic        cpu_run, cpu_rstn, halted;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_run_ctrl #(.RST_CYCLES(RST_CYC), .PC_W(32), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt), .cmd_rst(cmd_rst),
    .bp_en(bp_en), .bp_addr(bp_addr), .if_pc(if_pc), .cpu_stop(cpu_stop),
    .cpu_run(cpu_run), .cpu_rstn(cpu_rstn), .halted(halted),
    .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  int          m_mode     = M_RST;
  int          m_rst_left = RST_CYC;
  bit          m_skip     = 1'b0;
  int          m_cause    = 0;
  longint      m_cycles   = 0;
  int          m_wd       = 0;
  bit          m_r, m_hit, m_wdh;

  function automatic bit m_wd_hit();
`ifdef RUN_WATCHDOG_EN
    return (m_mode == M_RUN) && (m_wd >= WDOG);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_run_now();
    bit hit;
    hit = bp_en && !m_skip && (if_pc == bp_addr);
    if (m_mode == M_STEP) return 1'b1;
    if (m_mode == M_RUN)
      return !(hit || cpu_stop || cmd_halt || cmd_rst || m_wd_hit());
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode = M_RST; m_rst_left = RST_CYC; m_skip = 0; m_cause = 0; m_cycles = 0; m_wd = 0;
    end else begin
      m_r   = m_run_now();
      m_hit = bp_en && !m_skip && (if_pc == bp_addr);
      m_wdh = m_wd_hit();
      if (cmd_rst && m_mode != M_RST) begin
        m_mode = M_RST; m_rst_left = RST_CYC; m_cycles = 0; m_cause = 0;
      end else begin
        if (m_r && m_cycles < 64'hFFFF_FFFF) m_cycles++;
        if (m_mode == M_RST) begin
          m_rst_left--;
          if (m_rst_left == 0) begin m_mode = M_HALT; m_cause = 0; end
        end else if (m_mode == M_HALT) begin
          if (!cmd_halt && cmd_step) begin m_mode = M_STEP; m_skip = 1; m_cause = 0; end
          else if (!cmd_halt && cmd_run) begin m_mode = M_RUN; m_skip = 1; m_cause = 0; m_wd = 0; end
        end else if (m_mode == M_STEP) begin
          m_mode = M_HALT; m_cause = 0;
        end else begin
          if (cmd_halt)      begin m_mode = M_HALT; m_cause = 0; end
          else if (cpu_stop) begin m_mode = M_HALT; m_cause = 2; end
          else if (m_hit)    begin m_mode = M_HALT; m_cause = 1; end
          else if (m_wdh)    begin m_mode = M_HALT; m_cause = 3; end
          if (m_r) begin m_skip = 0; m_wd++; end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_cmds();
    cmd_run = 0; cmd_step = 0; cmd_halt = 0; cmd_rst = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int lows;
    rstn = 0; clear_cmds(); bp_en = 0; cpu_stop = 0; if_pc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (cpu_rstn !== 1'b0) $display("FAIL rst_cpu_rstn got=%0b exp=0", cpu_rstn); else n_pass++;
    n_checks++; if (cpu_run !== 1'b0) $display("FAIL rst_cpu_run got=%0b exp=0", cpu_run); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL rst_halted got=%0b exp=0", halted); else n_pass++;
    next_cycle();
    rstn = 1;
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpu_rstn === 1'b0) lows++; else break;
    end
    n_checks++; if (lows != RST_CYC) $display("FAIL rst_low_cycles got=%0d exp=%0d", lows, RST_CYC); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL rst_then_halted got=%0b exp=1", halted); else n_pass++;
    n_checks++; if (halt_cause !== 2'd0) $display("FAIL rst_cause got=%0d exp=0", halt_cause); else n_pass++;
    n_checks++; if (cpu_run !== 1'b0) $display("FAIL rst_halt_run got=%0b exp=0", cpu_run); else n_pass++;
    n_checks++; if (cycle_cnt !== 32'd0) $display("FAIL rst_cycle_cnt got=%0d exp=0", cycle_cnt); else n_pass++;
    next_cycle();
  endtask

  task automatic test_step();
    int pulses = 0;
    for (int k = 0; k < 3; k++) begin
      cmd_step = 1;
      @(negedge clk); if (cpu_run === 1'b1) pulses++;
      next_cycle();
      cmd_step = 0;
      repeat (3) begin
        @(negedge clk); if (cpu_run === 1'b1) pulses++;
        next_cycle();
      end
      @(negedge clk);
      n_checks++; if (halted !== 1'b1) $display("FAIL step_halted_%0d got=%0b exp=1", k, halted); else n_pass++;
      next_cycle();
    end
    n_checks++; if (pulses != 3) $display("FAIL step_pulses got=%0d exp=3", pulses); else n_pass++;
    n_checks++; if (cycle_cnt !== 32'd3) $display("FAIL step_cycle_cnt got=%0d exp=3", cycle_cnt); else n_pass++;
  endtask

  task automatic test_breakpoint();
    bit hit = 0, ran;
    bp_en = 1; bp_addr = 32'h10; if_pc = 0;
    cmd_run = 1; next_cycle(); cmd_run = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (if_pc == 32'h10) begin
        hit = 1;
        n_checks++; if (cpu_run !== 1'b0) $display("FAIL bp_same_cycle got=%0b exp=0", cpu_run); else n_pass++;
      end else begin
        n_checks++; if (cpu_run !== 1'b1) $display("FAIL bp_run_pc%0h got=%0b exp=1", if_pc, cpu_run); else n_pass++;
      end
      ran = cpu_run;
      next_cycle();
      if (ran && !hit) if_pc += 4;
    end
    n_checks++; if (!hit) $display("FAIL bp_timeout got=0 exp=1"); else n_pass++;
    @(negedge clk);
    n_checks++; if (halt_cause !== 2'd1 || halted !== 1'b1)
      $display("FAIL bp_cause got=%0d/%0b exp=1/1", halt_cause, halted); else n_pass++;
    next_cycle();
    cmd_run = 1; next_cycle(); cmd_run = 0;
    @(negedge clk);
    n_checks++; if (cpu_run !== 1'b1) $display("FAIL bp_skip_resume got=%0b exp=1", cpu_run); else n_pass++;
    next_cycle();
    repeat (2) begin
      if_pc += 4;
      @(negedge clk);
      n_checks++; if (cpu_run !== 1'b1) $display("FAIL bp_continue got=%0b exp=1", cpu_run); else n_pass++;
      next_cycle();
    end
    cmd_halt = 1;
    @(negedge clk);
    n_checks++; if (cpu_run !== 1'b0) $display("FAIL halt_gate got=%0b exp=0", cpu_run); else n_pass++;
    next_cycle(); cmd_halt = 0;
    @(negedge clk);
    n_checks++; if (halt_cause !== 2'd0 || halted !== 1'b1)
      $display("FAIL halt_cmd_cause got=%0d/%0b exp=0/1", halt_cause, halted); else n_pass++;
    next_cycle();
    bp_en = 0;
  endtask

  task automatic test_stop_priority();
    bp_en = 1; bp_addr = 32'h40; if_pc = 0;
    cmd_run = 1; next_cycle(); cmd_run = 0;
    next_cycle();
    if_pc = 32'h40; cpu_stop = 1;
    @(negedge clk);
    n_checks++; if (cpu_run !== 1'b0) $display("FAIL stop_gate got=%0b exp=0", cpu_run); else n_pass++;
    next_cycle(); cpu_stop = 0;
    @(negedge clk);
    n_checks++; if (halt_cause !== 2'd2) $display("FAIL stop_over_bp got=%0d exp=2", halt_cause); else n_pass++;
    next_cycle();
    if_pc = 0;
    cmd_run = 1; next_cycle(); cmd_run = 0;
    next_cycle();
    cmd_halt = 1; cpu_stop = 1;
    @(negedge clk);
    n_checks++; if (cpu_run !== 1'b0) $display("FAIL halt_stop_gate got=%0b exp=0", cpu_run); else n_pass++;
    next_cycle(); cmd_halt = 0; cpu_stop = 0;
    @(negedge clk);
    n_checks++; if (halt_cause !== 2'd0) $display("FAIL halt_over_stop got=%0d exp=0", halt_cause); else n_pass++;
    next_cycle();
    bp_en = 0;
  endtask

  task automatic test_rst_cmd();
    int lows = 0;
    cmd_run = 1; next_cycle(); cmd_run = 0;
    repeat (2) next_cycle();
    cmd_rst = 1; cmd_run = 1;
    @(negedge clk);
    n_checks++; if (cpu_run !== 1'b0) $display("FAIL rstcmd_gate got=%0b exp=0", cpu_run); else n_pass++;
    next_cycle(); clear_cmds();
    @(negedge clk);
    n_checks++; if (cycle_cnt !== 32'd0) $display("FAIL rstcmd_cycle_cnt got=%0d exp=0", cycle_cnt); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      if (cpu_rstn === 1'b0) lows++; else break;
      next_cycle();
      @(negedge clk);
    end
    n_checks++; if (lows != RST_CYC) $display("FAIL rstcmd_low_cycles got=%0d exp=%0d", lows, RST_CYC); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL rstcmd_halted got=%0b exp=1", halted); else n_pass++;
    next_cycle();
  endtask

  task automatic test_async_reset();
    int lows = 0;
    cmd_run = 1; next_cycle(); cmd_run = 0;
    @(negedge clk);
    n_checks++; if (cpu_run !== 1'b1) $display("FAIL async_pre_run got=%0b exp=1", cpu_run); else n_pass++;
    #2 rstn = 0;
    #1;
    n_checks++; if (cpu_run !== 1'b0 || cpu_rstn !== 1'b0)
      $display("FAIL async_drop got=%0b/%0b exp=0/0", cpu_run, cpu_rstn); else n_pass++;
    next_cycle();
    rstn = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpu_rstn === 1'b0) lows++; else break;
    end
    n_checks++; if (lows != RST_CYC) $display("FAIL async_low_cycles got=%0d exp=%0d", lows, RST_CYC); else n_pass++;
    n_checks++; if (cycle_cnt !== 32'd0) $display("FAIL async_cycle_cnt got=%0d exp=0", cycle_cnt); else n_pass++;
    next_cycle();
  endtask

  task automatic test_watchdog();
    int runs = 0;
    bp_en = 0; cpu_stop = 0;
    cmd_run = 1; next_cycle(); cmd_run = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (halted === 1'b1) break;
      if (cpu_run === 1'b1) runs++;
      next_cycle();
    end
`ifdef RUN_WATCHDOG_EN
    n_checks++; if (runs != WDOG) $display("FAIL wdog_runs got=%0d exp=%0d", runs, WDOG); else n_pass++;
    n_checks++; if (halted !== 1'b1 || halt_cause !== 2'd3)
      $display("FAIL wdog_cause got=%0b/%0d exp=1/3", halted, halt_cause); else n_pass++;
    next_cycle();
`else
    n_checks++; if (runs != 60) $display("FAIL nowdog_runs got=%0d exp=60", runs); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL nowdog_halted got=%0b exp=0", halted); else n_pass++;
    cmd_halt = 1; next_cycle(); cmd_halt = 0;
    @(negedge clk);
    n_checks++; if (halt_cause !== 2'd0) $display("FAIL nowdog_cause got=%0d exp=0", halt_cause); else n_pass++;
    next_cycle();
`endif
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 800; i++) begin
      cmd_run  = ($urandom_range(0, 9) == 0);
      cmd_step = ($urandom_range(0, 11) == 0);
      cmd_halt = ($urandom_range(0, 19) == 0);
      cmd_rst  = ($urandom_range(0, 49) == 0);
      cpu_stop = ($urandom_range(0, 9) == 0);
      bp_en    = $urandom_range(0, 1);
      bp_addr  = 32'($urandom_range(0, 3)) << 2;
      if_pc    = 32'($urandom_range(0, 3)) << 2;
      @(negedge clk);
      n_checks++;
      if (cpu_run !== m_run_now() || cpu_rstn !== (m_mode != M_RST) || halted !== (m_mode == M_HALT) ||
          halt_cause !== 2'(m_cause) || cycle_cnt !== 32'(m_cycles)) begin
        errs++;
        if (errs < 10)
          $display("FAIL rand_cyc%0d got run=%0b rstn=%0b hlt=%0b cause=%0d cnt=%0d exp run=%0b rstn=%0b hlt=%0b cause=%0d cnt=%0d",
                   i, cpu_run, cpu_rstn, halted, halt_cause, cycle_cnt,
                   m_run_now(), (m_mode != M_RST), (m_mode == M_HALT), m_cause, m_cycles);
      end else n_pass++;
      next_cycle();
    end
    clear_cmds(); cpu_stop = 0; bp_en = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_step();
    test_breakpoint();
    test_stop_priority();
    test_rst_cmd();
    test_async_reset();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
